// File: rtl/vend_dispense_sequencer_if.sv
// Vend request handshake between the vending FSM and the dispense sequencer.
interface vend_dispense_sequencer_if;
    logic       req_valid;
    logic [1:0] req_prod;
    logic [1:0] req_change;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_prod,
        output req_change,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_prod,
        input  req_change,
        output req_ready
    );
endinterface

// File: rtl/vend_dispense_sequencer.sv
// Dispense sequencer: buffers vend requests in a 2-entry FIFO, then runs the
// product motor, waits for the drop sensor and pulses the coin-return solenoid.
// All timing is paced by the slow tick enable.
module vend_dispense_sequencer #(
    parameter int unsigned MOTOR_TICKS    = 4,
    parameter int unsigned COIN_ON_TICKS  = 2,
    parameter int unsigned COIN_OFF_TICKS = 2,
    parameter int unsigned SENSE_TIMEOUT  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tick,
    vend_dispense_sequencer_if.slave        req_if,
    input  logic                            drop_sense,
    input  logic                            fault_clr,
    output logic [3:0]                      motor_sel,
    output logic                            coin_out,
    output logic                            done,
    output logic                            fault,
    output logic                            busy
);

    typedef enum logic [2:0] {
        StIdle,
        StMotor,
        StWaitDrop,
        StCoinOn,
        StCoinOff,
        StDone,
        StFault
    } state_e;

    localparam int unsigned MaxMs   = (MOTOR_TICKS > SENSE_TIMEOUT) ? MOTOR_TICKS : SENSE_TIMEOUT;
    localparam int unsigned MaxCoin = (COIN_ON_TICKS > COIN_OFF_TICKS) ? COIN_ON_TICKS
                                                                       : COIN_OFF_TICKS;
    localparam int unsigned CntMax  = (MaxMs > MaxCoin) ? MaxMs : MaxCoin;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] MotorLd   = CntW'(MOTOR_TICKS);
    localparam logic [CntW-1:0] SenseLd   = CntW'(SENSE_TIMEOUT);
    localparam logic [CntW-1:0] CoinOnLd  = CntW'(COIN_ON_TICKS);
    localparam logic [CntW-1:0] CoinOffLd = CntW'(COIN_OFF_TICKS);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      rem_q;

    // FIFO storage: each entry is {prod, change}
    logic [3:0] fifo_mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    logic       push;
    logic       pop;
    logic [3:0] head;
    logic [1:0] head_prod;
    logic [1:0] head_change;
    logic       cnt_one;

    // Handshake and status decode from registered state
    always_comb begin
        req_if.req_ready = rst_n && (count_q != 2'd2) && !fault;
        push             = req_if.req_valid && req_if.req_ready;
        // Only IDLE pops, so an entry pushed this clk is first seen next clk
        pop              = (state_q == StIdle) && tick && (count_q != 2'd0);
        head             = fifo_mem_q[rd_ptr_q];
        head_prod        = head[3:2];
        head_change      = head[1:0];
        cnt_one          = (cnt_q == CntOne);
        busy             = (state_q != StIdle) || (count_q != 2'd0);
    end

    // Request FIFO: push is not tick-gated, simultaneous push/pop keeps count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= {req_if.req_prod, req_if.req_change};
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Actuator sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= 2'd0;
            motor_sel <= 4'd0;
            coin_out  <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        rem_q     <= head_change;
                        cnt_q     <= MotorLd;
                        motor_sel <= 4'b0001 << head_prod;
                        state_q   <= StMotor;
                    end
                end
                StMotor: begin
                    if (tick) begin
                        if (cnt_one) begin
                            motor_sel <= 4'd0;
                            cnt_q     <= SenseLd;
                            state_q   <= StWaitDrop;
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                end
                StWaitDrop: begin
                    if (tick) begin
                        // A sensed drop takes priority over an expiring timeout
                        if (drop_sense) begin
                            if (rem_q != 2'd0) begin
                                coin_out <= 1'b1;
                                cnt_q    <= CoinOnLd;
                                state_q  <= StCoinOn;
                            end else begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end
                        end else if (cnt_one) begin
                            fault   <= 1'b1;
                            state_q <= StFault;
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                end
                StCoinOn: begin
                    if (tick) begin
                        if (cnt_one) begin
                            coin_out <= 1'b0;
                            cnt_q    <= CoinOffLd;
                            rem_q    <= rem_q - 2'd1;
                            state_q  <= StCoinOff;
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                end
                StCoinOff: begin
                    if (tick) begin
                        if (cnt_one) begin
                            if (rem_q != 2'd0) begin
                                coin_out <= 1'b1;
                                cnt_q    <= CoinOnLd;
                                state_q  <= StCoinOn;
                            end else begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                StFault: begin
                    // The faulted request is dropped; queued entries stay put
                    if (fault_clr) begin
                        fault   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    motor_sel <= 4'd0;
                    coin_out  <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Scoreboard bench for the dispense sequencer: stimulus queues the expected
// dispense profile, a negedge monitor measures what the actuators did.
module tb_vend_dispense_sequencer;

    localparam int MotorTicks = 4;
    localparam int CoinOn     = 2;
    localparam int CoinOff    = 2;
    localparam int SenseTo    = 8;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       tick       = 1'b0;
    logic       drop_sense = 1'b0;
    logic       fault_clr  = 1'b0;
    logic [3:0] motor_sel;
    logic       coin_out;
    logic       done;
    logic       fault;
    logic       busy;

    vend_dispense_sequencer_if req_if ();

    vend_dispense_sequencer #(
        .MOTOR_TICKS   (MotorTicks),
        .COIN_ON_TICKS (CoinOn),
        .COIN_OFF_TICKS(CoinOff),
        .SENSE_TIMEOUT (SenseTo)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .req_if    (req_if),
        .drop_sense(drop_sense),
        .fault_clr (fault_clr),
        .motor_sel (motor_sel),
        .coin_out  (coin_out),
        .done      (done),
        .fault     (fault),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int div    = 1;
    int tick_cnt = 0;

    typedef struct {
        logic [1:0] prod;
        int         coins;
        int         motor_clks;
        int         hi_clks;
        int         lo_clks;
        bit         will_fault;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Tick pacing: one tick every div clocks
    always @(posedge clk) begin
        #1;
        if (tick_cnt >= div - 1) begin
            tick_cnt = 0;
            tick     = 1'b1;
        end else begin
            tick_cnt = tick_cnt + 1;
            tick     = 1'b0;
        end
    end

    // Monitor state
    int         m_motor_clks = 0;
    logic [3:0] m_motor_val  = 4'd0;
    int         m_coins      = 0;
    int         m_hi         = 0;
    int         m_lo         = 0;
    bit         m_gap        = 1'b0;
    int         m_done_len   = 0;
    logic       m_coin_prev  = 1'b0;
    logic       m_done_prev  = 1'b0;
    logic       m_fault_prev = 1'b0;

    task automatic clear_accum();
        m_motor_clks = 0;
        m_motor_val  = 4'd0;
        m_coins      = 0;
        m_hi         = 0;
        m_lo         = 0;
        m_gap        = 1'b0;
    endtask

    // Monitor: measures actuator activity and checks it against the queue head
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] exp_sel;
        logic       ok;
        if (!rst_n) begin
            clear_accum();
            m_done_len   = 0;
            m_coin_prev  = 1'b0;
            m_done_prev  = 1'b0;
            m_fault_prev = 1'b0;
        end else begin
            ok = ((motor_sel & (motor_sel - 4'd1)) == 4'd0) && !((motor_sel != 4'd0) && coin_out);
            check("actuator_exclusive", ok, 1);
            if (motor_sel != 4'd0) begin
                m_motor_clks++;
                m_motor_val = motor_sel;
            end
            if (coin_out) begin
                if (!m_coin_prev && m_gap) begin
                    check("coin_has_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("coin_gap_clks", m_lo, exp_q[0].lo_clks);
                end
                m_gap = 1'b0;
                m_hi++;
            end else begin
                if (m_coin_prev) begin
                    m_coins++;
                    check("coin_has_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("coin_high_clks", m_hi, exp_q[0].hi_clks);
                    m_hi  = 0;
                    m_gap = 1'b1;
                    m_lo  = 0;
                end
                if (m_gap && !done) m_lo++;
            end
            if (done) begin
                m_done_len++;
            end else if (m_done_len != 0) begin
                check("done_pulse_clks", m_done_len, 1);
                m_done_len = 0;
            end
            if (done && !m_done_prev) begin
                check("done_has_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e       = exp_q.pop_front();
                    exp_sel = 4'b0001 << e.prod;
                    check("done_motor_sel", m_motor_val, exp_sel);
                    check("done_motor_clks", m_motor_clks, e.motor_clks);
                    check("done_coin_count", m_coins, e.coins);
                    if (e.coins > 0) check("final_gap_clks", m_lo, e.lo_clks);
                    check("done_without_fault_expected", e.will_fault, 0);
                end
                clear_accum();
            end
            if (fault && !m_fault_prev) begin
                check("fault_has_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e       = exp_q.pop_front();
                    exp_sel = 4'b0001 << e.prod;
                    check("fault_expected", e.will_fault, 1);
                    check("fault_motor_sel", m_motor_val, exp_sel);
                    check("fault_motor_clks", m_motor_clks, e.motor_clks);
                    check("fault_coin_count", m_coins, 0);
                end
                clear_accum();
            end
            m_coin_prev  = coin_out;
            m_done_prev  = done;
            m_fault_prev = fault;
        end
    end

    task automatic push(input logic [1:0] p, input logic [1:0] c, input logic exp_ready,
                        input bit will_fault);
        exp_t e;
        check($sformatf("req_ready_at_push_p%0d_c%0d", p, c), req_if.req_ready, exp_ready);
        req_if.req_valid  = 1'b1;
        req_if.req_prod   = p;
        req_if.req_change = c;
        if (exp_ready) begin
            e.prod       = p;
            e.coins      = int'(c);
            e.motor_clks = MotorTicks * div;
            e.hi_clks    = CoinOn * div;
            e.lo_clks    = CoinOff * div;
            e.will_fault = will_fault;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
        req_if.req_valid = 1'b0;
    endtask

    // which: 0 motor active, 1 coin_out, 2 busy, 3 fault
    task automatic wait_sig(input string name, input int which, input logic val, input int budget);
        int   n;
        bit   hit;
        logic s;
        n   = 0;
        hit = 1'b0;
        while (n < budget) begin
            case (which)
                0:       s = (motor_sel != 4'd0);
                1:       s = coin_out;
                2:       s = busy;
                default: s = fault;
            endcase
            if (s === val) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
            n++;
        end
        check({"wait_", name}, hit, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [3:0] act;
        req_if.req_valid  = 1'b0;
        req_if.req_prod   = 2'd0;
        req_if.req_change = 2'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_ready", req_if.req_ready, 0);
        check("rst_motor_sel", motor_sel, 0);
        check("rst_coin_out", coin_out, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", req_if.req_ready, 1);
        @(posedge clk);
        #2;

        // 1: single dispense, no change, tick every clk
        div        = 1;
        drop_sense = 1'b1;
        push(2'd2, 2'd0, 1'b1, 1'b0);
        wait_sig("t1_idle", 2, 1'b0, 100);
        check("t1_drained", exp_q.size(), 0);

        // 2: three coins, tick every 4 clks
        div = 4;
        repeat (4) @(posedge clk);
        #2;
        push(2'd1, 2'd3, 1'b1, 1'b0);
        wait_sig("t2_idle", 2, 1'b0, 400);
        check("t2_drained", exp_q.size(), 0);

        // 3: fill FIFO while first request runs; third extra is refused
        div = 1;
        repeat (2) @(posedge clk);
        #2;
        push(2'd0, 2'd1, 1'b1, 1'b0);
        wait_sig("t3_motor", 0, 1'b1, 20);
        push(2'd1, 2'd0, 1'b1, 1'b0);
        push(2'd3, 2'd2, 1'b1, 1'b0);
        push(2'd2, 2'd2, 1'b0, 1'b0);
        wait_sig("t3_idle", 2, 1'b0, 300);
        check("t3_drained", exp_q.size(), 0);

        // 4: drop timeout, queued request held until fault_clr
        drop_sense = 1'b0;
        push(2'd0, 2'd1, 1'b1, 1'b1);
        wait_sig("t4_motor_on", 0, 1'b1, 20);
        push(2'd3, 2'd0, 1'b1, 1'b0);
        wait_sig("t4_motor_off", 0, 1'b0, 20);
        n = 0;
        while (!fault && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t4_fault_ticks_after_motor_off", n, SenseTo);
        check("t4_req_ready_in_fault", req_if.req_ready, 0);
        repeat (5) @(posedge clk);
        #2;
        check("t4_no_pop_in_fault", motor_sel, 0);
        check("t4_fault_held", fault, 1);
        fault_clr  = 1'b1;
        drop_sense = 1'b1;
        @(posedge clk);
        #2;
        fault_clr = 1'b0;
        check("t4_fault_cleared", fault, 0);
        wait_sig("t4_idle", 2, 1'b0, 200);
        check("t4_drained", exp_q.size(), 0);

        // 5: drop arrives on the last timeout tick
        drop_sense = 1'b0;
        push(2'd1, 2'd1, 1'b1, 1'b0);
        wait_sig("t5_motor_on", 0, 1'b1, 20);
        wait_sig("t5_motor_off", 0, 1'b0, 20);
        repeat (SenseTo - 1) @(posedge clk);
        #2;
        drop_sense = 1'b1;
        wait_sig("t5_coin_on", 1, 1'b1, 5);
        check("t5_no_fault", fault, 0);
        wait_sig("t5_idle", 2, 1'b0, 100);
        check("t5_drained", exp_q.size(), 0);

        // 6: reset during COIN_ON with one entry queued
        push(2'd2, 2'd2, 1'b1, 1'b0);
        wait_sig("t6_motor_on", 0, 1'b1, 20);
        push(2'd0, 2'd0, 1'b1, 1'b0);
        wait_sig("t6_coin_on", 1, 1'b1, 50);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        check("t6_coin_off_in_reset", coin_out, 0);
        check("t6_busy_in_reset", busy, 0);
        check("t6_req_ready_in_reset", req_if.req_ready, 0);
        check("t6_motor_in_reset", motor_sel, 0);
        rst_n = 1'b1;
        #1;
        check("t6_req_ready_after_release", req_if.req_ready, 1);
        act = 4'd0;
        repeat (12) begin
            @(posedge clk);
            #2;
            act = act | motor_sel | {3'd0, coin_out | done | busy};
        end
        check("t6_no_activity_after_reset", act, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
